led_blink_scheduler: RTL and testbench
======================================

LED_BLINK_SCHEDULER -- requirements
Module: led_blink_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of event requesters (2..8).
REQ-002 Parameter ON_CYCLES, default 1024, LED on-time per blink in clk cycles (>=1).
REQ-003 Parameter OFF_CYCLES, default 1024, LED off-time between blinks of one burst (>=1).
REQ-004 Parameter GAP_CYCLES, default 4096, dark time after each burst (>=1).
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 pulse_in  input  N_REQ  per-requester event strobe, level-sampled every cycle.
REQ-008 led_out  output  1  registered LED drive, 1 = lit.
REQ-009 busy  output  1  registered, 1 whenever the FSM is not IDLE.
REQ-010 grant_id  output  clog2(N_REQ)  registered index of the requester in service; holds its last value when IDLE.

Function
REQ-011 Pending bit pend[i] SHALL set on any cycle pulse_in[i]=1; it clears only on the grant cycle of i, and clear wins over a same-cycle pulse_in[i].
REQ-012 FSM states SHALL be IDLE, ON, OFF, GAP.
REQ-013 IDLE with any pend bit set SHALL grant one requester and enter ON at the next edge, latching grant_id and blink count = grant_id+1.
REQ-014 Arbitration SHALL select the lowest-index pending requester (fixed priority) unless the round-robin option is compiled in.
REQ-015 ON SHALL last exactly ON_CYCLES cycles; then OFF if blinks remain, else GAP.
REQ-016 OFF SHALL last exactly OFF_CYCLES cycles, then return to ON.
REQ-017 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE; grant evaluation occurs in IDLE only, with a minimum of one cycle spent in IDLE.
REQ-018 led_out SHALL be 1 exactly while the state is ON.
REQ-019 busy SHALL be 1 exactly while the state is ON, OFF or GAP.
REQ-020 Latency: pulse_in sampled at edge k sets pend at edge k; led_out rises at edge k+2 if IDLE.
REQ-021 A single down-counter of width clog2(max(ON,OFF,GAP)+1) SHALL be used; it reloads on every state entry and never wraps.
REQ-022 Pulses for any requester arriving mid-burst SHALL be held in pend and serviced after GAP; repeated pulses coalesce into one service.

Reset
REQ-023 Asserted rst_n SHALL immediately force state=IDLE, led_out=0, busy=0, grant_id=0, pend=0, counter=0, rr pointer=0.
REQ-024 Deassertion SHALL be synchronized (2-flop) before releasing the FSM; pulse_in is ignored until release.

Configuration
REQ-025 Macro LED_SCHED_ROUND_ROBIN_EN defined: round-robin arbitration, priority starting at (last grant_id+1) mod N_REQ.
REQ-026 Macro absent: fixed priority per REQ-014, and no rr pointer register exists.

Structure
REQ-027 Package led_sched_pkg SHALL hold the state enum, the counter-width function and the state encoding constants.
REQ-028 Sub-module led_sched_arb SHALL implement the combinational-plus-pointer arbiter (pend in, grant index/valid out).

Verification (ON=4, OFF=3, GAP=8, N_REQ=4)
REQ-029 One-cycle pulse_in=0001 at edge 0 -> led_out=1 edges 2..5, busy=1 edges 2..13, grant_id=0, then IDLE.
REQ-030 pulse_in=0100 -> three 4-cycle lit windows separated by 3 dark cycles, then 8-cycle GAP, grant_id=2.
REQ-031 pulse_in=1010 in one cycle -> fixed: id1 burst (2 blinks), then id3 (4 blinks); round-robin after a prior grant of 3, next 1011 -> id0 first.
REQ-032 rst_n low during the second ON of an id1 burst -> led_out=0 and busy=0 with no clock edge; no service after release.
REQ-033 pulse_in[1] on the grant cycle of id1 -> absorbed; pulse_in[1] during OFF -> exactly one repeat burst after GAP.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED blink scheduler.
// Round-robin arbitration is enabled by defining LED_SCHED_ROUND_ROBIN_EN.
package led_sched_pkg;

    localparam logic [1:0] ST_ENC_IDLE = 2'd0;
    localparam logic [1:0] ST_ENC_ON   = 2'd1;
    localparam logic [1:0] ST_ENC_OFF  = 2'd2;
    localparam logic [1:0] ST_ENC_GAP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_ENC_IDLE,
        ST_ON   = ST_ENC_ON,
        ST_OFF  = ST_ENC_OFF,
        ST_GAP  = ST_ENC_GAP
    } state_t;

    // One counter serves all timed states, so it must hold the longest duration.
    function automatic int cnt_width(input int on_c, input int off_c, input int gap_c);
        int m;
        m = on_c;
        if (off_c > m) m = off_c;
        if (gap_c > m) m = gap_c;
        return $clog2(m + 1);
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/led_sched_arb.sv
// Requester arbiter: picks one pending index; fixed priority by default,
// round-robin with a pointer register when LED_SCHED_ROUND_ROBIN_EN is defined.
module led_sched_arb
    import led_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
`ifdef LED_SCHED_ROUND_ROBIN_EN
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_take,
`endif
    input  logic [N_REQ-1:0]         i_pend,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_valid
);

    localparam int ID_W = $clog2(N_REQ);

`ifdef LED_SCHED_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;

    // Search starts one past the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_take) begin
            r_ptr <= ID_W'(wrap_inc(int'(o_grant_id), N_REQ));
        end
    end

    always_comb begin
        o_valid    = 1'b0;
        o_grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_valid && i_pend[(int'(r_ptr) + k) % N_REQ]) begin
                o_valid    = 1'b1;
                o_grant_id = ID_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end
`else
    always_comb begin
        o_valid    = 1'b0;
        o_grant_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_pend[k]) begin
                o_valid    = 1'b1;
                o_grant_id = ID_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/led_blink_scheduler.sv
// LED blink scheduler: requester i is shown as a burst of i+1 blinks followed by a dark gap.
// Define LED_SCHED_ROUND_ROBIN_EN for round-robin instead of fixed-priority arbitration.
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ON_CYCLES  = 1024,
    parameter int OFF_CYCLES = 1024,
    parameter int GAP_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         pulse_in,
    output logic                     led_out,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
    localparam int BLK_W = $clog2(N_REQ + 1);

    logic [1:0]       r_sync;
    logic             w_run;
    logic [N_REQ-1:0] r_pend;
    logic [N_REQ-1:0] w_clr;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [BLK_W-1:0] r_blinks;
    logic             w_take;
    logic             w_dec;
    logic [ID_W-1:0]  w_grant;
    logic             w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_run = r_sync[1];

    led_sched_arb #(
        .N_REQ      (N_REQ)
    ) u_arb (
`ifdef LED_SCHED_ROUND_ROBIN_EN
        .clk        (clk),
        .rst_n      (rst_n),
        .i_take     (w_take),
`endif
        .i_pend     (r_pend),
        .o_grant_id (w_grant),
        .o_valid    (w_valid)
    );

    assign w_clr = w_take ? (N_REQ'(1) << w_grant) : '0;

    // Clearing the granted bit takes precedence over a same-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend | (w_run ? pulse_in : '0)) & ~w_clr;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_take     = 1'b0;
        w_dec      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_run && w_valid) begin
                    w_next     = ST_ON;
                    w_take     = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(ON_CYCLES - 1);
                end
            end
            ST_ON: begin
                if (r_cnt == '0) begin
                    w_load = 1'b1;
                    if (r_blinks > BLK_W'(1)) begin
                        w_next     = ST_OFF;
                        w_dec      = 1'b1;
                        w_load_val = CNT_W'(OFF_CYCLES - 1);
                    end else begin
                        w_next     = ST_GAP;
                        w_load_val = CNT_W'(GAP_CYCLES - 1);
                    end
                end
            end
            ST_OFF: begin
                if (r_cnt == '0) begin
                    w_next     = ST_ON;
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(ON_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_blinks <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_cnt <= w_load_val;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_take) begin
                r_blinks <= BLK_W'(int'(w_grant) + 1);
            end else if (w_dec) begin
                r_blinks <= r_blinks - 1'b1;
            end
        end
    end

    // Outputs are a registered image of the state, so a pulse at edge k lights the LED at k+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out  <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            led_out <= (r_state == ST_ON);
            busy    <= (r_state != ST_IDLE);
            if (w_take) begin
                grant_id <= w_grant;
            end
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Self-checking bench for led_blink_scheduler with ON=4, OFF=3, GAP=8, N_REQ=4.
// Expected traces are hand-derived burst timelines; corner cases use short directed sequences.
module tb_led_blink_scheduler;

    localparam int N_REQ = 4;
    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int GAP_C = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pulse_in = 4'b0000;
    logic       led_out;
    logic       busy;
    logic [1:0] grant_id;

    always #5 clk = ~clk;

    led_blink_scheduler #(
        .N_REQ      (N_REQ),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse_in   (pulse_in),
        .led_out    (led_out),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    typedef struct {
        logic [3:0] pulse;
        logic       led;
        logic       bsy;
        logic [1:0] gid;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails = 0;
    int   ledRises;
    int   busyRises;
    logic prevLed;
    logic prevBusy;

    task automatic checkOutput(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    // Drive inputs just after an edge; outputs are then examined 1ns after the next edge.
    task automatic applyStimulus(input logic [3:0] p);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [3:0] p, input logic l, input logic b, input logic [1:0] g);
        vecs.push_back('{pulse: p, led: l, bsy: b, gid: g});
    endtask

    // Pulse edge (optional), grant edge, then id+1 lit windows separated by OFF, then GAP.
    task automatic addBurst(input logic [3:0] p, input int id, input int gidPrev, input bit withPulse);
        if (withPulse) addVec(p, 1'b0, 1'b0, 2'(gidPrev));
        addVec(4'b0000, 1'b0, 1'b0, 2'(id));
        for (int b = 0; b <= id; b++) begin
            repeat (ON_C) addVec(4'b0000, 1'b1, 1'b1, 2'(id));
            if (b < id) repeat (OFF_C) addVec(4'b0000, 1'b0, 1'b1, 2'(id));
        end
        repeat (GAP_C) addVec(4'b0000, 1'b0, 1'b1, 2'(id));
    endtask

    task automatic addIdle(input int n, input int gid);
        repeat (n) addVec(4'b0000, 1'b0, 1'b0, 2'(gid));
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].pulse);
            checkOutput({tag, ".led"},  i, {3'b000, led_out}, {3'b000, vecs[i].led});
            checkOutput({tag, ".busy"}, i, {3'b000, busy},    {3'b000, vecs[i].bsy});
            checkOutput({tag, ".gid"},  i, {2'b00, grant_id}, {2'b00, vecs[i].gid});
        end
        vecs.delete();
    endtask

    task automatic clearCounts();
        ledRises  = 0;
        busyRises = 0;
        prevLed   = led_out;
        prevBusy  = busy;
    endtask

    task automatic stepAndCount(input logic [3:0] p);
        applyStimulus(p);
        if (led_out && !prevLed) ledRises++;
        if (busy && !prevBusy) busyRises++;
        prevLed  = led_out;
        prevBusy = busy;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.led",  0, {3'b000, led_out}, 4'h0);
        checkOutput("reset.busy", 0, {3'b000, busy},    4'h0);
        checkOutput("reset.gid",  0, {2'b00, grant_id}, 4'h0);
        rst_n = 1'b1;
        repeat (3) applyStimulus(4'b0000);

        addBurst(4'b0001, 0, 0, 1'b1);
        addIdle(1, 0);
        runTable("id0");

        addBurst(4'b0100, 2, 0, 1'b1);
        addIdle(1, 2);
        runTable("id2");

        addBurst(4'b1010, 1, 2, 1'b1);
        addBurst(4'b0000, 3, 0, 1'b0);
        addIdle(1, 3);
        runTable("pair");

        addBurst(4'b1011, 0, 3, 1'b1);
        addBurst(4'b0000, 1, 0, 1'b0);
        addBurst(4'b0000, 3, 0, 1'b0);
        addIdle(2, 3);
        runTable("triple");

        // A pulse on the grant cycle is swallowed by the clear.
        clearCounts();
        stepAndCount(4'b0010);
        stepAndCount(4'b0010);
        repeat (40) stepAndCount(4'b0000);
        checkOutput("absorb.ledRises",  0, 4'(ledRises),  4'd2);
        checkOutput("absorb.busyRises", 0, 4'(busyRises), 4'd1);
        checkOutput("absorb.gid",       0, {2'b00, grant_id}, 4'd1);
        checkOutput("absorb.busyEnd",   0, {3'b000, busy}, 4'h0);

        // Two pulses during OFF coalesce into exactly one repeat burst.
        clearCounts();
        stepAndCount(4'b0010);
        repeat (5) stepAndCount(4'b0000);
        stepAndCount(4'b0010);
        stepAndCount(4'b0010);
        repeat (60) stepAndCount(4'b0000);
        checkOutput("repeat.ledRises",  0, 4'(ledRises),  4'd4);
        checkOutput("repeat.busyRises", 0, 4'(busyRises), 4'd2);
        checkOutput("repeat.busyEnd",   0, {3'b000, busy}, 4'h0);

        // Reset during the second lit window of an id1 burst.
        applyStimulus(4'b0010);
        repeat (9) applyStimulus(4'b0000);
        checkOutput("prereset.led", 0, {3'b000, led_out}, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async.led",  0, {3'b000, led_out}, 4'h0);
        checkOutput("async.busy", 0, {3'b000, busy},    4'h0);
        checkOutput("async.gid",  0, {2'b00, grant_id}, 4'h0);
        pulse_in = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("inreset.led",  0, {3'b000, led_out}, 4'h0);
        checkOutput("inreset.busy", 0, {3'b000, busy},    4'h0);
        rst_n = 1'b1;
        clearCounts();
        stepAndCount(4'b1111);
        repeat (40) stepAndCount(4'b0000);
        checkOutput("postreset.ledRises",  0, 4'(ledRises),  4'd0);
        checkOutput("postreset.busyRises", 0, 4'(busyRises), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
